// File: rtl/spi_reg_bridge.sv
// SPI command/data protocol bridge onto an 8-bit register bus with address auto-increment.
// Define SPI_REG_BRIDGE_ERR_CNT_EN to add a saturating frame-error counter readable at the top address.
module spi_reg_bridge #(
    parameter int          ADDR_W     = 7,
    parameter logic [7:0]  DUMMY_BYTE = 8'h00,
    parameter bit          AUTO_INC   = 1'b1
) (
    input  logic              clk,
    input  logic              sys_rst_n,
    input  logic              frame_active,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic [7:0]        tx_data,
    output logic              tx_load,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [7:0]        reg_rdata,
    output logic              busy,
    output logic              frame_err
`ifdef SPI_REG_BRIDGE_ERR_CNT_EN
    ,
    output logic [7:0]        err_count
`endif
);

    typedef enum logic [2:0] {IDLE, CMD, WR, RD_ISSUE, RD_CAPTURE, RD} state_t;

    state_t            state_q, state_d;
    logic              fa_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_load_q, tx_load_d;
    logic              reg_we_q, reg_we_d;
    logic [7:0]        reg_wdata_q, reg_wdata_d;
    logic              frame_err_q, frame_err_d;
    logic              data_seen_q, data_seen_d;
    logic [7:0]        rdata_mux;

    logic              rise, fall;
    logic [ADDR_W-1:0] step;

    assign rise = frame_active & ~fa_q;
    assign fall = ~frame_active & fa_q;
    assign step = ADDR_W'(AUTO_INC);

`ifdef SPI_REG_BRIDGE_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;
    logic       read_cnt;
    assign read_cnt  = (state_q == RD_CAPTURE) && (&addr_q);
    assign rdata_mux = read_cnt ? err_cnt_q : reg_rdata;
`else
    assign rdata_mux = reg_rdata;
`endif

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        tx_data_d   = tx_data_q;
        tx_load_d   = 1'b0;
        reg_we_d    = 1'b0;
        reg_wdata_d = reg_wdata_q;
        frame_err_d = 1'b0;
        data_seen_d = data_seen_q;

        // Post-increment lands the cycle after the write strobe so reg_addr is stable during it.
        if (reg_we_q) addr_d = addr_q + step;

        case (state_q)
            CMD: if (rx_valid) begin
                addr_d      = rx_data[ADDR_W-1:0];
                data_seen_d = 1'b0;
                state_d     = rx_data[7] ? RD_ISSUE : WR;
            end
            WR: if (rx_valid) begin
                reg_we_d    = 1'b1;
                reg_wdata_d = rx_data;
                data_seen_d = 1'b1;
            end
            RD_ISSUE:   state_d = RD_CAPTURE;
            RD_CAPTURE: begin
                tx_data_d = rdata_mux;
                tx_load_d = 1'b1;
                addr_d    = addr_q + step;
                state_d   = RD;
            end
            RD: if (rx_valid) state_d = RD_ISSUE;
            default: ;
        endcase

        if (rx_valid && !frame_active && !fa_q) frame_err_d = 1'b1;

        // A byte arriving with the falling edge is still processed above; only sequencing is cut.
        if (fall) begin
            if ((state_q == WR && !data_seen_q && !rx_valid) ||
                (state_q == CMD && rx_valid && !rx_data[7]))
                frame_err_d = 1'b1;
            state_d   = IDLE;
            tx_load_d = 1'b0;
            tx_data_d = tx_data_q;
        end

        if (rise) begin
            state_d   = CMD;
            tx_data_d = DUMMY_BYTE;
            tx_load_d = 1'b1;
        end
    end

`ifdef SPI_REG_BRIDGE_ERR_CNT_EN
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (frame_err_d && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        if (read_cnt && !fall) err_cnt_d = '0;
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) err_cnt_q <= '0;
        else            err_cnt_q <= err_cnt_d;
    end

    assign err_count = err_cnt_q;
`endif

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= IDLE;
            fa_q        <= 1'b0;
            addr_q      <= '0;
            tx_data_q   <= DUMMY_BYTE;
            tx_load_q   <= 1'b0;
            reg_we_q    <= 1'b0;
            reg_wdata_q <= '0;
            frame_err_q <= 1'b0;
            data_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fa_q        <= frame_active;
            addr_q      <= addr_d;
            tx_data_q   <= tx_data_d;
            tx_load_q   <= tx_load_d;
            reg_we_q    <= reg_we_d;
            reg_wdata_q <= reg_wdata_d;
            frame_err_q <= frame_err_d;
            data_seen_q <= data_seen_d;
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_load   = tx_load_q;
    assign reg_addr  = addr_q;
    assign reg_wdata = reg_wdata_q;
    assign reg_we    = reg_we_q;
    assign reg_re    = (state_q == RD_ISSUE);
    assign busy      = (state_q != IDLE);
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Scoreboard bench for spi_reg_bridge: frame-level reference model feeds expectation queues,
// a negedge monitor pops them on reg_we / reg_re / tx_load strobes.
module tb_spi_reg_bridge;

    logic       clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       frame_active = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic [7:0] tx_data;
    logic       tx_load;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata = 8'h00;
    logic       busy;
    logic       frame_err;
`ifdef SPI_REG_BRIDGE_ERR_CNT_EN
    logic [7:0] err_count;
`endif

    always #5 clk = ~clk;

    spi_reg_bridge #(.ADDR_W(7), .DUMMY_BYTE(8'h00), .AUTO_INC(1'b1)) dut (
        .clk(clk), .sys_rst_n(sys_rst_n), .frame_active(frame_active),
        .rx_valid(rx_valid), .rx_data(rx_data), .tx_data(tx_data), .tx_load(tx_load),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
        .reg_rdata(reg_rdata), .busy(busy), .frame_err(frame_err)
`ifdef SPI_REG_BRIDGE_ERR_CNT_EN
        , .err_count(err_count)
`endif
    );

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] init_val(input int i);
        case (i)
            0: return 8'h41;
            1: return 8'h52;
            2: return 8'h47;
            3: return 8'h55;
            4: return 8'h53;
            default: return 8'((i * 37) + 11);
        endcase
    endfunction

    // Register-bus slave: read data valid the cycle after reg_re.
    logic [7:0] mem [128];
    logic       mem_init = 1'b1;
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 128; i++) mem[i] <= init_val(i);
        end else begin
            if (reg_re) reg_rdata <= mem[reg_addr];
            if (reg_we) mem[reg_addr] <= reg_wdata;
        end
    end

    logic [7:0]  ref_mem [128];
    int unsigned ref_err = 0;
    int unsigned exp_err = 0;
    int unsigned got_err = 0;
    logic [14:0] exp_wr [$];
    logic [6:0]  exp_rd [$];
    logic [7:0]  exp_tx [$];
    logic [7:0]  dbuf [8];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: strobe seen with no expectation queued", name);
    endtask

    int unsigned rx_cyc = 0;
    initial begin
        logic [14:0] w;
        forever begin
            @(negedge clk);
            if (sys_rst_n) begin
                if (rx_valid) rx_cyc = cyc;
                if (reg_we) begin
                    if (exp_wr.size() == 0) unexpected("reg_we");
                    else begin
                        w = exp_wr.pop_front();
                        check("wr_addr", 32'(reg_addr), 32'(w[14:8]));
                        check("wr_data", 32'(reg_wdata), 32'(w[7:0]));
                        check("wr_latency", cyc, rx_cyc + 1);
                    end
                end
                if (reg_re) begin
                    if (exp_rd.size() == 0) unexpected("reg_re");
                    else begin
                        check("rd_addr", 32'(reg_addr), 32'(exp_rd.pop_front()));
                        check("rd_latency", cyc, rx_cyc + 1);
                    end
                end
                if (tx_load) begin
                    if (exp_tx.size() == 0) unexpected("tx_load");
                    else check("tx_data", 32'(tx_data), 32'(exp_tx.pop_front()));
                end
                if (frame_err) got_err++;
            end
        end
    end

    task automatic model_err();
        exp_err++;
`ifdef SPI_REG_BRIDGE_ERR_CNT_EN
        if (ref_err != 255) ref_err++;
`endif
    endtask

    task automatic send_byte(input logic [7:0] b, input bit drop);
        @(posedge clk); #1;
        rx_valid = 1'b1;
        rx_data  = b;
        if (drop) frame_active = 1'b0;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        repeat (9) @(posedge clk);
    endtask

    // Byte 0 = command; a read returns DUMMY then mem[A], mem[A+1], ... plus one prefetch.
    task automatic frame(input logic [7:0] cmd, input int n, input bit drop_last);
        logic [6:0] a;
        logic [7:0] v;
        a = cmd[6:0];
        exp_tx.push_back(8'h00);
        if (cmd[7]) begin
            for (int i = 0; i <= n; i++) begin
                exp_rd.push_back(a);
                v = ref_mem[a];
`ifdef SPI_REG_BRIDGE_ERR_CNT_EN
                if (a == 7'h7F) begin
                    v = 8'(ref_err);
                    ref_err = 0;
                end
`endif
                exp_tx.push_back(v);
                a = a + 7'd1;
            end
        end else begin
            for (int i = 0; i < n; i++) begin
                exp_wr.push_back({a, dbuf[i]});
                ref_mem[a] = dbuf[i];
                a = a + 7'd1;
            end
            if (n == 0) model_err();
        end
        @(posedge clk); #1;
        frame_active = 1'b1;
        repeat (3) @(posedge clk);
        send_byte(cmd, drop_last && n == 0);
        for (int i = 0; i < n; i++) send_byte(dbuf[i], drop_last && i == n - 1);
        if (!drop_last) begin
            repeat (4) @(posedge clk); #1;
            frame_active = 1'b0;
        end
        repeat (4) @(posedge clk);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) ref_mem[i] = init_val(i);

        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            frame_active = ~frame_active;
            @(negedge clk);
            check("rst_tx_data", 32'(tx_data), 32'h00);
            check("rst_strobes", {28'd0, tx_load, reg_we, reg_re, frame_err}, 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
        end
        @(posedge clk); #1;
        frame_active = 1'b0;
        @(posedge clk); #1;
        sys_rst_n = 1'b1;
        mem_init  = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_addr", 32'(reg_addr), 32'd0);
        check("post_rst_wdata", 32'(reg_wdata), 32'd0);

        for (int i = 0; i < 8; i++) dbuf[i] = 8'hFF;
        frame(8'h80, 7, 1'b0);

        dbuf[0] = 8'h01;
        frame(8'h05, 1, 1'b0);
        check("led_mem", 32'(mem[5]), 32'h01);
        frame(8'h85, 2, 1'b0);

        dbuf[0] = 8'hAA;
        dbuf[1] = 8'hBB;
        frame(8'h7F, 2, 1'b0);
        check("wrap_mem_7f", 32'(mem[127]), 32'hAA);
        check("wrap_mem_00", 32'(mem[0]), 32'hBB);

        dbuf[0] = 8'h33;
        frame(8'h20, 1, 1'b1);
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_mem", 32'(mem[32]), 32'h33);

        frame(8'h10, 0, 1'b0);

        @(posedge clk); #1;
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        model_err();
        repeat (4) @(negedge clk);
        check("err_pulses", got_err, exp_err);
`ifdef SPI_REG_BRIDGE_ERR_CNT_EN
        check("err_count", 32'(err_count), ref_err);
`endif

        for (int f = 0; f < 24; f++) begin
            for (int i = 0; i < 8; i++) dbuf[i] = 8'($urandom);
            frame(8'($urandom), int'($urandom_range(0, 4)), 1'b0);
        end

        repeat (6) @(negedge clk);
        check("final_err_pulses", got_err, exp_err);
        check("final_wr_queue", exp_wr.size(), 0);
        check("final_rd_queue", exp_rd.size(), 0);
        check("final_tx_queue", exp_tx.size(), 0);
        check("final_busy", 32'(busy), 32'd0);
`ifdef SPI_REG_BRIDGE_ERR_CNT_EN
        check("final_err_count", 32'(err_count), ref_err);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_reg_bridge.md
Name: spi_reg_bridge

Overview:
- Protocol layer directly downstream of the SPI slave byte engine: consumes received bytes, decodes a command byte, drives the internal register bus (LED control, system ID, etc.) and supplies the next byte to be shifted out on miso.
- One frame = one cs_n low period: a command byte followed by N data bytes, with address auto-increment.
- Runs entirely in the `clk` domain. The SPI slave delivers already-synchronised frame and byte strobes.

Parameters:
- ADDR_W, 7, register address width; the command byte carries address in bits [ADDR_W-1:0], ADDR_W <= 7.
- DUMMY_BYTE, 8'h00, byte presented on tx while no register data is available.
- AUTO_INC, 1, 1 = increment address after each data byte, 0 = hold address.

Ports:
- clk  in  1  system clock
- sys_rst_n  in  1  asynchronous active-low reset
- frame_active  in  1  high while cs_n is asserted (synchronised by SPI slave)
- rx_valid  in  1  one-cycle pulse, a full byte was received
- rx_data  in  8  received byte, valid with rx_valid
- tx_data  out  8  next byte to shift; SPI slave latches it on each rx_valid and at frame start
- tx_load  out  1  one-cycle pulse, tx_data updated
- reg_addr  out  ADDR_W  register bus address
- reg_wdata  out  8  register bus write data
- reg_we  out  1  one-cycle write strobe
- reg_re  out  1  one-cycle read strobe
- reg_rdata  in  8  read data, valid exactly one cycle after reg_re
- busy  out  1  high when state != IDLE
- frame_err  out  1  one-cycle pulse on protocol error

Behaviour:
- Reset (async assert, sync deassert by the top): state=IDLE, tx_data=DUMMY_BYTE, all strobes 0, reg_addr=0, reg_wdata=0, busy=0.
- Command byte: bit7=1 read, bit7=0 write; bits[ADDR_W-1:0]=start address A. Bits between ADDR_W and 6 are ignored.
- FSM states: IDLE, CMD, WR, RD_ISSUE, RD_CAPTURE, RD.
- IDLE -> CMD on the frame_active rising edge. The same cycle loads tx_data=DUMMY_BYTE and pulses tx_load.
- CMD + rx_valid, write: latch A, go to WR.
- CMD + rx_valid, read: latch A, go to RD_ISSUE.
- RD_ISSUE:
  - Drive reg_re=1 with reg_addr=current address, for one cycle, at t+1 after rx_valid.
  - Go to RD_CAPTURE.
- RD_CAPTURE (t+2):
  - tx_data=reg_rdata; pulse tx_load.
  - If AUTO_INC, address <= address+1.
  - Go to RD.
- RD + rx_valid: rx_data is ignored; go to RD_ISSUE (prefetch the next address).
- Read timing within a frame:
  - Byte 0 = command, byte 1 returns DUMMY_BYTE.
  - Byte k (k>=2) returns reg[A+k-2].
  - One address beyond the last byte clocked is always prefetched. Registers with read side effects must tolerate this.
- WR + rx_valid: at t+1 drive reg_we=1, reg_addr=current address, reg_wdata=rx_data. The address then increments if AUTO_INC. Stay in WR.
- Address arithmetic is modulo 2^ADDR_W, so 2^ADDR_W-1 wraps to 0.
- A falling edge of frame_active in any state returns the FSM to IDLE next cycle.
  - A reg_re already issued completes, but no tx_load follows.
  - If rx_valid and the frame_active fall occur in the same cycle, the byte is processed first: a write strobe is still issued, then IDLE.
- An rx_valid while frame_active=0 is ignored and pulses frame_err.
- A write frame that ends with zero data bytes pulses frame_err.
- A frame_active rise while not IDLE is impossible by construction; treat it as the start of a new frame.
- rx_valid pulses are at least 8 clk apart; back-to-back pulses need not be supported.

Optional Feature:
- Macro: SPI_REG_BRIDGE_ERR_CNT_EN.
- When defined: adds output err_count[7:0], reset 0, which increments on every frame_err pulse and saturates at 8'hFF. A read of address 2^ADDR_W-1 returns err_count in place of reg_rdata, and that read clears the count.
- When undefined: no err_count port, and address 2^ADDR_W-1 is an ordinary register.

Test Plan:
- Reset sequencing: hold sys_rst_n=0 with frame_active toggling -> no strobes, tx_data=8'h00. Release reset -> state=IDLE, busy=0.
- ID read: frame with cmd 8'h80 then 7x 8'hFF, register model mem[0..4]="ARGUS" -> reg_re issued at addresses 0..7 in order. Bytes 2..6 shifted out = 8'h41,8'h52,8'h47,8'h55,8'h53.
- LED write: frame cmd 8'h05, data 8'h01 -> exactly one reg_we, reg_addr=5, reg_wdata=8'h01, issued 1 cycle after rx_valid.
- LED readback: frame cmd 8'h85 followed by 2 dummy bytes -> byte 2 returns 8'h01.
- Wrap and burst: write cmd 8'h7F then 8'hAA, 8'hBB -> writes at addr 7F=AA and 00=BB.
- Abort and errors:
  - Frame drop in the same cycle as a data byte -> the write is still issued, then IDLE.
  - Empty write frame (8'h10 only) -> frame_err pulse.
  - rx_valid with frame_active=0 -> frame_err pulse.
  - With the macro defined, err_count=2 after both errors.
